// File: rtl/cdf_accum_ctrl_pkg.sv
// Shared types, widths and default address map for the histogram-equalisation CDF stage.
// The scratch address and data widths are fixed here so the interface and top agree.
package cdf_accum_ctrl_pkg;

    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned DEF_NUM_BINS  = 64;
    localparam int unsigned DEF_HIST_BASE = 0;
    localparam int unsigned DEF_CDF_BASE  = 64;
    localparam int unsigned DIV_OUT_BASE  = 128;
    localparam int unsigned DEF_RD_LAT    = 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } cdf_state_e;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } sc_wr_t;

    // Running-sum adder that clamps at all-ones instead of wrapping.
    function automatic data_t sat_add(input data_t a, input data_t b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W] ? '1 : sum[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/cdf_accum_ctrl_if.sv
// Control/scratch-memory bundle between the CDF accumulator and its neighbours.
interface cdf_accum_ctrl_if;
    import cdf_accum_ctrl_pkg::*;

    logic  start;
    data_t sc_rd_data;
    addr_t sc_rd_addr;
    logic  sc_rd_en;
    addr_t sc_wt_addr;
    data_t sc_wt_data;
    logic  sc_wt_en;
    logic  busy;
    logic  cdf_done;
    data_t cdf_min;
    data_t cdf_total;

    modport slave (
        input  start, sc_rd_data,
        output sc_rd_addr, sc_rd_en, sc_wt_addr, sc_wt_data, sc_wt_en,
               busy, cdf_done, cdf_min, cdf_total
    );

    modport master (
        output start, sc_rd_data,
        input  sc_rd_addr, sc_rd_en, sc_wt_addr, sc_wt_data, sc_wt_en,
               busy, cdf_done, cdf_min, cdf_total
    );
endinterface

// File: rtl/cdf_accum_ctrl_rd_valid_pipe.sv
// Tracks outstanding scratch reads: the output bit marks read data valid RD_LAT cycles later.
module cdf_accum_ctrl_rd_valid_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic vld_i,
    output logic vld_o,
    output logic busy_o
);

    logic [RD_LAT-1:0] pipe_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= vld_i;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign vld_o  = pipe_q[RD_LAT-1];
    assign busy_o = |pipe_q;

endmodule

// File: rtl/cdf_accum_ctrl.sv
// Streams histogram bins from scratch memory, writes the saturating running sum (CDF) back,
// and reports the first non-zero CDF value and the total; cdf_done launches the divider.
module cdf_accum_ctrl
    import cdf_accum_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BINS  = DEF_NUM_BINS,
    parameter int unsigned HIST_BASE = DEF_HIST_BASE,
    parameter int unsigned CDF_BASE  = DEF_CDF_BASE,
    parameter int unsigned RD_LAT    = DEF_RD_LAT
) (
    input  logic             clk,
    input  logic             reset,
    cdf_accum_ctrl_if.slave  bus
);

    localparam addr_t LAST_IDX = ADDR_W'(NUM_BINS - 1);
    localparam addr_t ALL_BINS = ADDR_W'(NUM_BINS);

    cdf_state_e state_q, state_d;
    addr_t      rd_cnt_q, rd_cnt_d, wt_cnt_q, wt_cnt_d;
    addr_t      rd_addr_q, rd_addr_d;
    data_t      acc_q, acc_d, min_q, min_d, total_q, total_d;
    sc_wr_t     wt_q, wt_d;
    logic       rd_en_q, rd_en_d, wt_en_q, wt_en_d;
    logic       busy_q, busy_d, done_q, done_d, found_q, found_d;
    logic       rd_vld, rd_pending;
    data_t      acc_n;

    cdf_accum_ctrl_rd_valid_pipe #(.RD_LAT(RD_LAT)) u_rd_valid_pipe (
        .clk    (clk),
        .reset  (reset),
        .vld_i  (rd_en_q),
        .vld_o  (rd_vld),
        .busy_o (rd_pending)
    );

    assign acc_n = sat_add(acc_q, bus.sc_rd_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // The first read issues on the start edge, so RUN only covers the remaining bins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN:   if (rd_cnt_q == LAST_IDX) state_d = ST_DRAIN;
            ST_DRAIN: if (!rd_pending && !rd_en_q && !wt_en_q && (wt_cnt_q == ALL_BINS))
                          state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_cnt_d  = rd_cnt_q;
        wt_en_d   = 1'b0;
        wt_d      = wt_q;
        wt_cnt_d  = wt_cnt_q;
        acc_d     = acc_q;
        found_d   = found_q;
        min_d     = min_q;
        total_d   = total_q;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d     = '0;
                    min_d     = '0;
                    total_d   = '0;
                    found_d   = 1'b0;
                    wt_cnt_d  = '0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = ADDR_W'(HIST_BASE);
                    rd_cnt_d  = ADDR_W'(1);
                end
            end
            ST_RUN: begin
                rd_en_d   = 1'b1;
                rd_addr_d = ADDR_W'(HIST_BASE) + rd_cnt_q;
                rd_cnt_d  = rd_cnt_q + ADDR_W'(1);
            end
            default: ;
        endcase

        // Returned bin: accumulate, then write the new CDF entry on the following cycle.
        if (rd_vld) begin
            acc_d   = acc_n;
            wt_en_d = 1'b1;
            wt_d    = '{addr: ADDR_W'(CDF_BASE) + wt_cnt_q, data: acc_n};
            wt_cnt_d = wt_cnt_q + ADDR_W'(1);
            if (!found_q && (acc_n != '0)) begin
                found_d = 1'b1;
                min_d   = acc_n;
            end
            if (wt_cnt_q == LAST_IDX) total_d = acc_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_cnt_q  <= '0;
            wt_en_q   <= 1'b0;
            wt_q      <= '0;
            wt_cnt_q  <= '0;
            acc_q     <= '0;
            found_q   <= 1'b0;
            min_q     <= '0;
            total_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_cnt_q  <= rd_cnt_d;
            wt_en_q   <= wt_en_d;
            wt_q      <= wt_d;
            wt_cnt_q  <= wt_cnt_d;
            acc_q     <= acc_d;
            found_q   <= found_d;
            min_q     <= min_d;
            total_q   <= total_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sc_rd_en   = rd_en_q;
    assign bus.sc_rd_addr = rd_addr_q;
    assign bus.sc_wt_en   = wt_en_q;
    assign bus.sc_wt_addr = wt_q.addr;
    assign bus.sc_wt_data = wt_q.data;
    assign bus.busy       = busy_q;
    assign bus.cdf_done   = done_q;
    assign bus.cdf_min    = min_q;
    assign bus.cdf_total  = total_q;

endmodule
